operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Pipeline stage between decode and execute in the RV32 core.
- Drives the register file read addresses and captures the returned operands.
- Tracks pending destination writes with a scoreboard, stalling RAW hazards.
- Optionally bypasses same-cycle writeback data.
- One-entry output register with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, data width (mirrors core_config_pkg::XLEN)
- REG_ADDR_W, 5, register index width (mirrors core_config_pkg::REG_ADDR_W)
- REG_COUNT, 32, number of architectural registers (mirrors core_config_pkg::REG_COUNT)
- UOP_W, 16, opaque micro-op bits carried from decode to execute

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global stage enable; all state holds when low
- flush  in  1  kill the instruction held in this stage; decode handshake blocked this cycle
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  stage accepts the decode instruction
- dec_rs1, dec_rs2  in  REG_ADDR_W  source indices
- dec_rs1_used, dec_rs2_used  in  1  source actually read by the op
- dec_rd  in  REG_ADDR_W  destination index
- dec_rd_we  in  1  op writes rd
- dec_imm  in  XLEN  immediate
- dec_pc  in  XLEN  instruction PC
- dec_uop  in  UOP_W  micro-op
- rf_ra1, rf_ra2  out  REG_ADDR_W  register file read addresses (combinational from dec_rs1/dec_rs2)
- rf_rd1, rf_rd2  in  XLEN  register file read data (asynchronous)
- wb_we  in  1  writeback write enable (same signal as the register file write port)
- wb_wa  in  REG_ADDR_W  writeback address
- wb_wd  in  XLEN  writeback data
- kill_valid  in  1  a downstream instruction with a pending rd was squashed
- kill_rd  in  REG_ADDR_W  its destination; clears its scoreboard bit
- ex_valid  out  1  output register holds a valid instruction
- ex_ready  in  1  execute accepts
- ex_rs1_val, ex_rs2_val  out  XLEN  operand values
- ex_rd  out  REG_ADDR_W  destination index
- ex_rd_we  out  1  op writes rd
- ex_imm  out  XLEN  immediate
- ex_pc  out  XLEN  instruction PC
- ex_uop  out  UOP_W  micro-op

Behaviour:
- Reset: all ex_* outputs are 0, ex_valid=0, scoreboard all 0. Reset mid-stall discards the held instruction.
- Scoreboard: REG_COUNT bits. A bit is set on ex handshake (ex_valid && ex_ready && clk_en) when ex_rd_we and ex_rd!=0. A bit is cleared on wb_we with wb_wa, or on kill_valid with kill_rd.
  - Bit 0 is never set.
  - Set and clear of the same index in one cycle: set wins.
- Hazard for source s:
  - s_used && s!=0 && (sb[s] || (ex_valid && ex_rd_we && ex_rd==s)).
  - The sb[s] term is suppressed when the bypass condition below holds.
- Bypass: wb_we && wb_wa==s && s!=0 selects wb_wd over rf data.
- dec_ready = clk_en && !flush && !hazard(rs1) && !hazard(rs2) && (!ex_valid || ex_ready).
- Capture on dec_valid && dec_ready: operands, payload and ex_valid=1. Latency 1 cycle from decode to ex_valid.
- Output is held stable while ex_valid && !ex_ready.
- ex_valid is cleared when ex_ready && no capture, or when flush.
- flush: the held instruction never sets its scoreboard bit. Flush has priority over an ex handshake in the same cycle.
- x0 always reads as 0 regardless of rf data.
- clk_en low: no state changes; dec_ready=0.

Optional Feature:
- Macro OPFETCH_WB_BYPASS_EN.
- Defined: same-cycle writeback bypass as above.
- Undefined: no bypass; a source hits a hazard while sb[s] is set even if the write lands this cycle, costing one extra stall cycle; the operand is then read from the register file.

Decomposition:
- core_config_pkg gains UOP_W and typedef opf_payload_t (rd, rd_we, imm, pc, uop) shared by decode, operand_fetch and execute.
- Sub-module reg_scoreboard (set/clear ports, per-index busy output) is natural and reusable by the load/store unit.

Test Plan:
- Reset, rf_rd1=0x1234 on rs1=5, dec_valid -> next cycle ex_valid=1, ex_rs1_val=0x1234, all ex_* 0 during reset.
- Issue rd=7 (accepted by ex), then rs1=7 -> dec_ready=0 until wb_we wa=7 wd=0xAA. Bypass build: accepted that cycle with ex_rs1_val=0xAA. Non-bypass build: accepted one cycle later.
- Back-to-back rd=3 then rs2=3 while first held (ex_ready=0) -> stall; no capture; output stable.
- rs1=0 with rf_rd1=0xFFFF and sb irrelevant -> ex_rs1_val=0, no stall.
- Flush with a held rd=9 instruction -> ex_valid=0 next cycle, sb[9]=0, a following rs1=9 is not stalled.
- kill_valid rd=4 while a rs2=4 consumer is stalled -> consumer accepted next cycle; simultaneous set of 4 and wb clear of 4 -> bit remains set.

Source files
------------

// File: rtl/core_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_config_pkg
// Description : Core-wide widths and the decode->execute payload type.
// Revision    : 1.0 - initial release
// ============================================================================
package core_config_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam int UOP_W      = 16;

    // Non-operand part of an instruction, carried unchanged decode -> execute.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_we;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic [UOP_W-1:0]      uop;
    } opf_payload_t;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register busy bits; one set port, two clear ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_a_en,
    input  logic [REG_ADDR_W-1:0] clr_a_idx,
    input  logic                  clr_b_en,
    input  logic [REG_ADDR_W-1:0] clr_b_idx,
    output logic [REG_COUNT-1:0]  busy
);

    logic [REG_COUNT-1:0] r_busy;
    logic [REG_COUNT-1:0] w_next;

    // Clears are applied first so a same-index set in the same cycle wins.
    always_comb begin
        w_next = r_busy;
        if (clr_a_en) w_next[clr_a_idx] = 1'b0;
        if (clr_b_en) w_next[clr_b_idx] = 1'b0;
        if (set_en)   w_next[set_idx]   = 1'b1;
        w_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (clk_en) begin
            r_busy <= w_next;
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Decode->execute stage: RF read, RAW scoreboard stall, output
//               register. Define OPFETCH_WB_BYPASS_EN for writeback bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W,
    parameter int REG_COUNT  = core_config_pkg::REG_COUNT,
    parameter int UOP_W      = core_config_pkg::UOP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_rd_we,
    input  logic [XLEN-1:0]       dec_imm,
    input  logic [XLEN-1:0]       dec_pc,
    input  logic [UOP_W-1:0]      dec_uop,
    output logic [REG_ADDR_W-1:0] rf_ra1,
    output logic [REG_ADDR_W-1:0] rf_ra2,
    input  logic [XLEN-1:0]       rf_rd1,
    input  logic [XLEN-1:0]       rf_rd2,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_wa,
    input  logic [XLEN-1:0]       wb_wd,
    input  logic                  kill_valid,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       ex_rs1_val,
    output logic [XLEN-1:0]       ex_rs2_val,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_rd_we,
    output logic [XLEN-1:0]       ex_imm,
    output logic [XLEN-1:0]       ex_pc,
    output logic [UOP_W-1:0]      ex_uop
);

    import core_config_pkg::*;

    logic [REG_COUNT-1:0] w_busy;
    logic                 w_byp1, w_byp2;
    logic                 w_hz1, w_hz2;
    logic                 w_capture, w_ex_fire;
    logic [XLEN-1:0]      w_op1, w_op2;

    logic                 r_valid;
    opf_payload_t         r_payload;
    logic [XLEN-1:0]      r_rs1_val, r_rs2_val;

    assign rf_ra1 = dec_rs1;
    assign rf_ra2 = dec_rs2;

`ifdef OPFETCH_WB_BYPASS_EN
    assign w_byp1 = wb_we && (wb_wa == dec_rs1) && (dec_rs1 != '0);
    assign w_byp2 = wb_we && (wb_wa == dec_rs2) && (dec_rs2 != '0);
    assign w_op1  = (dec_rs1 == '0) ? '0 : (w_byp1 ? wb_wd : rf_rd1);
    assign w_op2  = (dec_rs2 == '0) ? '0 : (w_byp2 ? wb_wd : rf_rd2);
`else
    logic w_unused_wb_wd;
    assign w_byp1         = 1'b0;
    assign w_byp2         = 1'b0;
    assign w_unused_wb_wd = ^wb_wd;
    assign w_op1          = (dec_rs1 == '0) ? '0 : rf_rd1;
    assign w_op2          = (dec_rs2 == '0) ? '0 : rf_rd2;
`endif

    // The in-flight producer still sitting in the output register is a hazard
    // too: its scoreboard bit is only set once execute takes it.
    assign w_hz1 = dec_rs1_used && (dec_rs1 != '0) &&
                   ((w_busy[dec_rs1] && !w_byp1) ||
                    (r_valid && r_payload.rd_we && (r_payload.rd == dec_rs1)));
    assign w_hz2 = dec_rs2_used && (dec_rs2 != '0) &&
                   ((w_busy[dec_rs2] && !w_byp2) ||
                    (r_valid && r_payload.rd_we && (r_payload.rd == dec_rs2)));

    assign dec_ready = clk_en && !flush && !w_hz1 && !w_hz2 && (!r_valid || ex_ready);
    assign w_capture = dec_valid && dec_ready;
    assign w_ex_fire = r_valid && ex_ready && clk_en && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
        end else if (clk_en) begin
            if (w_capture) begin
                r_valid         <= 1'b1;
                r_rs1_val       <= w_op1;
                r_rs2_val       <= w_op2;
                r_payload.rd    <= dec_rd;
                r_payload.rd_we <= dec_rd_we;
                r_payload.imm   <= dec_imm;
                r_payload.pc    <= dec_pc;
                r_payload.uop   <= dec_uop;
            end else if (flush || ex_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    reg_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .REG_COUNT  (REG_COUNT)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .set_en    (w_ex_fire && r_payload.rd_we),
        .set_idx   (r_payload.rd),
        .clr_a_en  (wb_we),
        .clr_a_idx (wb_wa),
        .clr_b_en  (kill_valid),
        .clr_b_idx (kill_rd),
        .busy      (w_busy)
    );

    assign ex_valid   = r_valid;
    assign ex_rs1_val = r_rs1_val;
    assign ex_rs2_val = r_rs2_val;
    assign ex_rd      = r_payload.rd;
    assign ex_rd_we   = r_payload.rd_we;
    assign ex_imm     = r_payload.imm;
    assign ex_pc      = r_payload.pc;
    assign ex_uop     = r_payload.uop;

endmodule
`default_nettype wire
